// File: rtl/seg_rx.sv
// seg_rx: decodes a multiplexed, active-low 7-segment display bus back into frames of nibbles.
// Optional feature: define SEG_RX_DP_EN to capture the decimal point and include it in the stability compare.
module seg_rx #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic        seg_rx_port_clk,
  input  logic        seg_rx_port_rst,
  input  logic [6:0]  seg_rx_port_ssd,
  input  logic        seg_rx_port_odp,
  input  logic [7:0]  seg_rx_port_an,
  input  logic        seg_rx_port_ready,
  output logic [31:0] seg_rx_port_value,
  output logic [7:0]  seg_rx_port_dp,
  output logic [7:0]  seg_rx_port_blank,
  output logic [7:0]  seg_rx_port_bad,
  output logic        seg_rx_port_valid,
  output logic        seg_rx_port_err,
  output logic        seg_rx_port_ovr
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1) + 1;
  localparam logic [CW-1:0]  L_STABLE = CW'(STABLE_CYCLES);
  localparam logic [7:0]     L_DMASK  = 8'((9'd1 << DIGITS) - 9'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Returns {bad, blank, nibble} for an active-low {g..a} pattern.
  function automatic logic [5:0] f_decode(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'h40:   res = 6'h00;
      7'h79:   res = 6'h01;
      7'h24:   res = 6'h02;
      7'h30:   res = 6'h03;
      7'h19:   res = 6'h04;
      7'h12:   res = 6'h05;
      7'h02:   res = 6'h06;
      7'h78:   res = 6'h07;
      7'h00:   res = 6'h08;
      7'h10:   res = 6'h09;
      7'h08:   res = 6'h0A;
      7'h03:   res = 6'h0B;
      7'h46:   res = 6'h0C;
      7'h21:   res = 6'h0D;
      7'h06:   res = 6'h0E;
      7'h0E:   res = 6'h0F;
      7'h7F:   res = 6'b01_0000;
      default: res = 6'b10_0000;
    endcase
    return res;
  endfunction

  state_t         r_state, w_state_n;
  logic [CW-1:0]  r_cnt, w_run;
  logic [15:0]    r_prev, w_cur;
  logic [7:0]     w_an_eff, w_low;
  logic           w_none, w_onehot, w_multi, w_changed;
  logic           w_odp_eff, w_dp_bit;
  logic           w_sample, w_err_n, w_complete;
  logic [2:0]     w_idx;
  logic [5:0]     w_dec;
  logic [7:0]     r_mask, w_mask_n, w_mask_set;
  logic [31:0]    r_stg_val, w_stg_val_n;
  logic [7:0]     r_stg_dp, w_stg_dp_n, r_stg_blank, w_stg_blank_n, r_stg_bad, w_stg_bad_n;
  logic [31:0]    r_value;
  logic [7:0]     r_dp, r_blank, r_bad;
  logic           r_valid, r_err, r_ovr;

`ifdef SEG_RX_DP_EN
  assign w_odp_eff = seg_rx_port_odp;
`else
  logic w_unused_odp;
  assign w_unused_odp = seg_rx_port_odp;
  assign w_odp_eff    = 1'b1;
`endif

  // Anodes beyond DIGITS are forced inactive so they never select or disturb anything.
  assign w_an_eff  = seg_rx_port_an | ~L_DMASK;
  assign w_low     = ~w_an_eff;
  assign w_none    = (w_low == 8'd0);
  assign w_onehot  = !w_none && ((w_low & (w_low - 8'd1)) == 8'd0);
  assign w_multi   = !w_none && !w_onehot;
  assign w_cur     = {w_an_eff, seg_rx_port_ssd, w_odp_eff};
  assign w_changed = (w_cur != r_prev);
  assign w_dec     = f_decode(seg_rx_port_ssd);
  assign w_dp_bit  = ~w_odp_eff;

  // Run length of the current bus pattern, saturating at the threshold.
  always_comb begin
    w_run = r_cnt;
    if (w_changed) begin
      w_run = CW'(1);
    end else if (r_cnt >= L_STABLE) begin
      w_run = L_STABLE;
    end else begin
      w_run = r_cnt + CW'(1);
    end
  end

  // Active digit index from the one-hot anode pattern.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = w_low[i] ? 3'(i) : w_idx;
    end
  end

  // Next state, sample strobe and error pulse.
  always_comb begin
    w_state_n = r_state;
    w_sample  = 1'b0;
    w_err_n   = 1'b0;
    if (w_multi) begin
      w_state_n = IDLE;
      w_err_n   = w_changed;
    end else if (w_none) begin
      w_state_n = IDLE;
    end else if ((w_changed || (r_state != HELD)) && (w_run == L_STABLE)) begin
      w_sample  = 1'b1;
      w_state_n = HELD;
    end else if (w_changed || (r_state == IDLE)) begin
      w_state_n = SETTLE;
    end else begin
      w_state_n = r_state;
    end
  end

  // Frame staging: digit 0 opens a frame, full mask completes it.
  always_comb begin
    w_mask_n      = r_mask;
    w_stg_val_n   = r_stg_val;
    w_stg_dp_n    = r_stg_dp;
    w_stg_blank_n = r_stg_blank;
    w_stg_bad_n   = r_stg_bad;
    w_complete    = 1'b0;
    w_mask_set    = r_mask | (8'd1 << w_idx);
    if (w_multi) begin
      w_mask_n = 8'd0;
    end else if (w_sample && ((w_idx == 3'd0) || r_mask[0])) begin
      w_stg_val_n[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_stg_blank_n[w_idx]             = w_dec[4];
      w_stg_bad_n[w_idx]               = w_dec[5];
      w_stg_dp_n[w_idx]                = w_dp_bit;
      if (w_mask_set == L_DMASK) begin
        w_complete = 1'b1;
        w_mask_n   = 8'd0;
      end else begin
        w_mask_n = w_mask_set;
      end
    end else begin
      w_mask_n = r_mask;
    end
  end

  // FSM state, run counter and previous-bus register.
  always_ff @(posedge seg_rx_port_clk or posedge seg_rx_port_rst) begin
    if (seg_rx_port_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_prev  <= {8'hFF, 7'h7F, 1'b1};
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_run;
      r_prev  <= w_cur;
      r_err   <= w_err_n;
    end
  end

  // Staged frame storage.
  always_ff @(posedge seg_rx_port_clk or posedge seg_rx_port_rst) begin
    if (seg_rx_port_rst) begin
      r_mask      <= 8'd0;
      r_stg_val   <= 32'd0;
      r_stg_dp    <= 8'd0;
      r_stg_blank <= 8'd0;
      r_stg_bad   <= 8'd0;
    end else begin
      r_mask      <= w_mask_n;
      r_stg_val   <= w_stg_val_n;
      r_stg_dp    <= w_stg_dp_n;
      r_stg_blank <= w_stg_blank_n;
      r_stg_bad   <= w_stg_bad_n;
    end
  end

  // Output handshake: a frame finishing against an unaccepted one is dropped and flagged.
  always_ff @(posedge seg_rx_port_clk or posedge seg_rx_port_rst) begin
    if (seg_rx_port_rst) begin
      r_value <= 32'd0;
      r_dp    <= 8'd0;
      r_blank <= 8'd0;
      r_bad   <= 8'd0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_complete && !(r_valid && !seg_rx_port_ready)) begin
      r_value <= w_stg_val_n;
      r_dp    <= w_stg_dp_n;
      r_blank <= w_stg_blank_n;
      r_bad   <= w_stg_bad_n;
      r_valid <= 1'b1;
    end else if (w_complete) begin
      r_ovr <= 1'b1;
    end else if (r_valid && seg_rx_port_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign seg_rx_port_value = r_value;
  assign seg_rx_port_dp    = r_dp;
  assign seg_rx_port_blank = r_blank;
  assign seg_rx_port_bad   = r_bad;
  assign seg_rx_port_valid = r_valid;
  assign seg_rx_port_err   = r_err;
  assign seg_rx_port_ovr   = r_ovr;

endmodule

// File: tb/tb_seg_rx.sv
// Directed self-checking bench for seg_rx (DIGITS=8, STABLE_CYCLES=4).
module tb_seg_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ssd;
  logic        odp;
  logic [7:0]  an;
  logic        ready;
  logic [31:0] value;
  logic [7:0]  dp, blank, bad;
  logic        valid, err, ovr;

  int checks   = 0;
  int failures = 0;

  logic [55:0] seg_a, seg_z, seg_i, seg_m;
  logic [7:0]  exp_dp;

  always #5 clk = ~clk;

  seg_rx dut (
    .seg_rx_port_clk   (clk),
    .seg_rx_port_rst   (rst),
    .seg_rx_port_ssd   (ssd),
    .seg_rx_port_odp   (odp),
    .seg_rx_port_an    (an),
    .seg_rx_port_ready (ready),
    .seg_rx_port_value (value),
    .seg_rx_port_dp    (dp),
    .seg_rx_port_blank (blank),
    .seg_rx_port_bad   (bad),
    .seg_rx_port_valid (valid),
    .seg_rx_port_err   (err),
    .seg_rx_port_ovr   (ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [6:0] s, input logic o, input int n);
    an  = ~(8'd1 << d);
    ssd = s;
    odp = o;
    tick(n);
  endtask

  task automatic scan(input logic [55:0] segs, input int lo, input int hi);
    for (int d = lo; d <= hi; d++) show(d, segs[7*d +: 7], 1'b1, 6);
  endtask

  initial begin
    seg_a = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    seg_z = {8{7'h40}};
    seg_i = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    seg_m = {7'h00, 7'h78, 7'h7F, 7'h12, 7'h19, 7'h55, 7'h24, 7'h79};
`ifdef SEG_RX_DP_EN
    exp_dp = 8'h01;
`else
    exp_dp = 8'h00;
`endif
    rst = 1'b1; an = 8'hFF; ssd = 7'h7F; odp = 1'b1; ready = 1'b1;
    tick(2);
    chk("rst_value", value, 32'd0);
    chk("rst_dp", dp, 32'd0);
    chk("rst_blank", blank, 32'd0);
    chk("rst_bad", bad, 32'd0);
    chk("rst_valid", valid, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_ovr", ovr, 32'd0);
    rst = 1'b0;
    tick(1);

    // Basic scan, ready high: valid for exactly one cycle.
    scan(seg_a, 0, 6);
    show(7, seg_a[55:49], 1'b1, 4);
    chk("scan_valid", valid, 32'd1);
    chk("scan_value", value, 32'h87654321);
    chk("scan_blank", blank, 32'd0);
    chk("scan_bad", bad, 32'd0);
    tick(1);
    chk("scan_valid_clr", valid, 32'd0);
    tick(1);

    // Digit 3 too short to be sampled.
    ready = 1'b0;
    scan(seg_a, 0, 2);
    show(3, seg_a[27:21], 1'b1, 3);
    scan(seg_a, 4, 7);
    chk("short_no_valid", valid, 32'd0);
    scan(seg_a, 0, 7);
    chk("short_later_valid", valid, 32'd1);
    chk("short_later_value", value, 32'h87654321);
    chk("short_no_ovr", ovr, 32'd0);
    ready = 1'b1;
    tick(1);
    chk("short_valid_clr", valid, 32'd0);
    ready = 1'b0;

    // Illegal anode pattern aborts the frame.
    scan(seg_a, 0, 3);
    an = 8'hFC;
    tick(1);
    chk("abort_err_pulse", err, 32'd1);
    an = ~8'h10; ssd = seg_a[34:28];
    tick(1);
    chk("abort_err_clr", err, 32'd0);
    tick(5);
    scan(seg_a, 5, 7);
    chk("abort_no_valid", valid, 32'd0);
    scan(seg_a, 0, 7);
    chk("abort_later_valid", valid, 32'd1);
    ready = 1'b1;
    tick(1);
    chk("abort_valid_clr", valid, 32'd0);
    ready = 1'b0;

    // Overrun: second frame dropped while first is unaccepted.
    scan(seg_a, 0, 7);
    chk("ovr_first_valid", valid, 32'd1);
    chk("ovr_before", ovr, 32'd0);
    scan(seg_z, 0, 7);
    chk("ovr_kept_value", value, 32'h87654321);
    chk("ovr_valid_held", valid, 32'd1);
    chk("ovr_set", ovr, 32'd1);
    ready = 1'b1;
    tick(1);
    chk("ovr_valid_clr", valid, 32'd0);
    chk("ovr_sticky", ovr, 32'd1);
    ready = 1'b0;

    // Blank, undecodable pattern and decimal point.
    show(0, 7'h79, 1'b0, 6);
    scan(seg_m, 1, 7);
    chk("mix_valid", valid, 32'd1);
    chk("mix_value", value, 32'h87054021);
    chk("mix_blank", blank, 32'h20);
    chk("mix_bad", bad, 32'h04);
    chk("mix_dp", dp, {24'd0, exp_dp});
    ready = 1'b1;
    tick(1);
    chk("mix_valid_clr", valid, 32'd0);
    ready = 1'b0;

    // Frame completes on the same edge the previous one is accepted.
    scan(seg_a, 0, 7);
    chk("same_pre_valid", valid, 32'd1);
    scan(seg_i, 0, 6);
    show(7, seg_i[55:49], 1'b1, 3);
    ready = 1'b1;
    tick(1);
    chk("same_valid_kept", valid, 32'd1);
    chk("same_new_value", value, 32'h76543210);
    tick(1);
    chk("same_valid_clr", valid, 32'd0);
    ready = 1'b0;

    // Asynchronous reset while valid.
    scan(seg_a, 0, 7);
    chk("arst_pre_valid", valid, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 32'd0);
    chk("arst_value", value, 32'd0);
    chk("arst_ovr", ovr, 32'd0);
    chk("arst_dp", dp, 32'd0);
    chk("arst_blank", blank, 32'd0);
    chk("arst_bad", bad, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-frame discards staged digits.
    scan(seg_a, 0, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    scan(seg_a, 4, 7);
    chk("mrst_no_valid", valid, 32'd0);
    scan(seg_i, 0, 7);
    chk("mrst_valid", valid, 32'd1);
    chk("mrst_value", value, 32'h76543210);
    chk("mrst_ovr", ovr, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_rx.md
SEG_RX -- requirements
Module: seg_rx

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits decoded (1..8).
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical-input cycles required before a digit is sampled (>=1).
REQ-003 seg_rx_port_clk  input  1  sole clock; all logic on rising edge.
REQ-004 seg_rx_port_rst  input  1  asynchronous, active-high reset.
REQ-005 seg_rx_port_ssd  input  7  segments, active-low, bit order {g,f,e,d,c,b,a}; synchronous to seg_rx_port_clk.
REQ-006 seg_rx_port_odp  input  1  decimal point, active-low.
REQ-007 seg_rx_port_an  input  8  digit anodes, active-low; bit i selects digit i; bits >= DIGITS ignored.
REQ-008 seg_rx_port_ready  input  1  consumer accepts the current frame.
REQ-009 seg_rx_port_value  output  32  decoded nibbles; digit i at bits [4i+3:4i]; unused digits 0.
REQ-010 seg_rx_port_dp  output  8  decoded decimal points, active-high, bit i = digit i.
REQ-011 seg_rx_port_blank  output  8  bit i set when digit i was blank (7'h7F).
REQ-012 seg_rx_port_bad  output  8  bit i set when digit i held an undecodable pattern.
REQ-013 seg_rx_port_valid  output  1  a complete frame is presented.
REQ-014 seg_rx_port_err  output  1  one-cycle pulse on an illegal anode pattern.
REQ-015 seg_rx_port_ovr  output  1  sticky overrun flag.

Function
REQ-016 Decode table (active-low {g..a}) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-017 Blank 7'h7F SHALL decode to nibble 0 with blank bit set; any other unlisted pattern SHALL decode to nibble 0 with bad bit set.
REQ-018 FSM states SHALL be IDLE (no anode active), SETTLE (one-hot anode, counting), HELD (digit sampled, awaiting change).
REQ-019 Stability counter SHALL clear and the FSM SHALL enter SETTLE whenever {an, ssd, odp} differs from the previous cycle and an is one-hot.
REQ-020 A digit SHALL be sampled on the STABLE_CYCLES-th consecutive identical cycle, exactly once per activation, then the FSM SHALL enter HELD.
REQ-021 All anodes high SHALL return the FSM to IDLE with no error and no sample.
REQ-022 More than one anode low SHALL pulse seg_rx_port_err for one cycle, return to IDLE and abort the current frame.
REQ-023 Frame sync: captured-digit mask SHALL clear on reset or abort; samples are discarded until digit 0 is sampled, which starts a frame.
REQ-024 Re-sampling an already-captured digit within a frame SHALL overwrite its staged value.
REQ-025 When the mask covers all DIGITS, staged data SHALL load into the output registers and valid SHALL assert the next cycle; mask clears and a new frame awaits digit 0.
REQ-026 Outputs SHALL hold stable while valid=1; valid SHALL clear the cycle after valid&ready unless a new frame loads that same edge.
REQ-027 Frame completing while valid=1 and ready=0 SHALL be dropped, keeping old outputs, and SHALL set seg_rx_port_ovr.
REQ-028 Frame completing in the same cycle as valid&ready SHALL load the new frame with valid remaining 1 and no overrun.

Reset
REQ-029 Reset SHALL force FSM=IDLE, counter=0, mask=0, value=0, dp=0, blank=0, bad=0, valid=0, err=0, ovr=0, immediately and independent of the clock.
REQ-030 Reset asserted mid-frame SHALL discard staged digits; the first post-reset frame SHALL begin at digit 0.
REQ-031 ovr SHALL clear only on reset.

Configuration
REQ-032 Macro SEG_RX_DP_EN defined: odp sampled with each digit into seg_rx_port_dp and included in the stability compare.
REQ-033 SEG_RX_DP_EN undefined: seg_rx_port_dp SHALL be constant 0 and odp SHALL be ignored, including for stability.

Verification
REQ-034 Scan digits 0..7 each 6 cycles showing 1,2,3,4,5,6,7,8, ready=1 -> value=32'h87654321, valid one cycle, blank=0, bad=0.
REQ-035 Digit 3 held only 3 cycles (STABLE_CYCLES=4) -> digit 3 never sampled, no valid until a later full scan.
REQ-036 an=8'b11111100 for one cycle mid-frame -> err pulse one cycle, frame aborted, next valid only after a complete scan from digit 0.
REQ-037 Two full frames with ready=0 -> first frame held, ovr=1; then ready=1 -> valid clears next cycle, ovr stays 1.
REQ-038 Digit 5 shows 7'h7F, digit 2 shows 7'h55, odp low on digit 0, SEG_RX_DP_EN defined -> blank=8'h20, bad=8'h04, dp=8'h01.
REQ-039 Assert reset while valid=1 -> all outputs 0 the same cycle, before the next clock edge.
